handshake_stall_checker: RTL and testbench



---
 rtl/handshake_stall_checker.sv | 161 ++++++++++++++++
 tb/tb_handshake_stall_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_stall_checker.sv
// Multi-channel valid/ready monitor: flags valid drop, payload change and over-long stalls into sticky bits, latches first error.
// Flags are registered one cycle after the offending edge. Define HANDSHAKE_CHECK_FATAL_EN to stop simulation on any new error.
module handshake_stall_checker #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 11
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [CHANNELS-1:0]          valid,
  input  logic [CHANNELS-1:0]          ready,
  input  logic [CHANNELS*DATA_W-1:0]   data,
  output logic [CHANNELS-1:0]          err_valid_drop,
  output logic [CHANNELS-1:0]          err_data_change,
  output logic [CHANNELS-1:0]          err_timeout,
  output logic                         err_any,
  output logic [$clog2(CHANNELS):0]    first_err_chan,
  output logic [1:0]                   first_err_code
);
  localparam int CW = $clog2(CHANNELS) + 1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic {IDLE, STALLED} state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [DATA_W-1:0]   cap_q   [CHANNELS];
  logic [DATA_W-1:0]   cap_d   [CHANNELS];
  // Counter saturates at TIMEOUT, so a separate bit keeps the timeout to one report per stall.
  logic [CHANNELS-1:0] to_rep_q, to_rep_d;
  logic [CHANNELS-1:0] ev_vd, ev_dc, ev_to;
  logic                new_first;
  logic [CW-1:0]       new_chan;
  logic [1:0]          new_code;

  always_comb begin
    ev_vd    = '0;
    ev_dc    = '0;
    ev_to    = '0;
    to_rep_d = to_rep_q;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cap_d[i]   = cap_q[i];
      if (!enable) begin
        state_d[i]  = IDLE;
        cnt_d[i]    = '0;
        to_rep_d[i] = 1'b0;
      end else if (state_q[i] == IDLE) begin
        if (valid[i] && !ready[i]) begin
          state_d[i]  = STALLED;
          cap_d[i]    = data[i*DATA_W +: DATA_W];
          cnt_d[i]    = CNT_W'(1);
          to_rep_d[i] = 1'b0;
        end
      end else if (!valid[i]) begin
        ev_vd[i]   = 1'b1;
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        ev_dc[i] = (data[i*DATA_W +: DATA_W] != cap_q[i]);
        if (ready[i]) begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end else begin
          if (cnt_q[i] < TO_CNT)
            cnt_d[i] = cnt_q[i] + 1'b1;
          if ((TIMEOUT != 0) && (cnt_q[i] == TO_CNT) && !to_rep_q[i]) begin
            ev_to[i]    = 1'b1;
            to_rep_d[i] = 1'b1;
          end
        end
      end
    end

    // Descending scan so the lowest-indexed offending channel wins.
    new_first = 1'b0;
    new_chan  = '0;
    new_code  = 2'd0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ev_vd[i] || ev_dc[i] || ev_to[i]) begin
        new_first = 1'b1;
        new_chan  = CW'(i);
        new_code  = ev_vd[i] ? 2'd1 : (ev_dc[i] ? 2'd2 : 2'd3);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        cap_q[i]   <= '0;
      end
      to_rep_q        <= '0;
      err_valid_drop  <= '0;
      err_data_change <= '0;
      err_timeout     <= '0;
      first_err_chan  <= '0;
      first_err_code  <= 2'd0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        cap_q[i]   <= cap_d[i];
      end
      to_rep_q        <= to_rep_d;
      err_valid_drop  <= err_valid_drop | ev_vd;
      err_data_change <= err_data_change | ev_dc;
      err_timeout     <= err_timeout | ev_to;
      if ((first_err_code == 2'd0) && new_first) begin
        first_err_chan <= new_chan;
        first_err_code <= new_code;
      end
    end
  end

  assign err_any = |{err_valid_drop, err_data_change, err_timeout};

`ifndef SYNTHESIS
`ifndef PRINTF_COND
`define PRINTF_COND 1'b1
`endif
  logic [63:0] cycle_cnt;
  logic        print_en;
  assign print_en = `PRINTF_COND;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 64'd1;
  end

  always @(posedge clock) begin
    if (!reset && print_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ev_vd[i]) $display("[handshake_stall_checker] violation chan %0d code 1 cycle %0d", i, cycle_cnt);
        if (ev_dc[i]) $display("[handshake_stall_checker] violation chan %0d code 2 cycle %0d", i, cycle_cnt);
        if (ev_to[i]) $display("[handshake_stall_checker] violation chan %0d code 3 cycle %0d", i, cycle_cnt);
      end
    end
  end

`ifdef HANDSHAKE_CHECK_FATAL_EN
`ifndef STOP_COND
`define STOP_COND 1'b1
`endif
  logic stop_en;
  assign stop_en = `STOP_COND;
  always @(posedge clock) begin
    if (!reset && stop_en && ((ev_vd | ev_dc | ev_to) != '0))
      $fatal(1, "[handshake_stall_checker] protocol violation at cycle %0d", cycle_cnt);
  end
`endif
`endif

endmodule

// File: tb/tb_handshake_stall_checker.sv
// Randomised and directed bench for handshake_stall_checker against a stall-age reference model (two instances: TIMEOUT=8 and 0).
module tb_handshake_stall_checker;
  localparam int CH = 2;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset, enable;
  logic [CH-1:0] valid, ready;
  logic [CH*DW-1:0] data;

  logic [CH-1:0] vd0, dc0, to0, vd1, dc1, to1;
  logic any0, any1;
  logic [1:0] fch0, fch1, fcd0, fcd1;

  handshake_stall_checker #(.CHANNELS(CH), .DATA_W(DW), .TIMEOUT(8), .CNT_W(4)) dut_to (
    .clock(clock), .reset(reset), .enable(enable), .valid(valid), .ready(ready), .data(data),
    .err_valid_drop(vd0), .err_data_change(dc0), .err_timeout(to0), .err_any(any0),
    .first_err_chan(fch0), .first_err_code(fcd0));

  handshake_stall_checker #(.CHANNELS(CH), .DATA_W(DW), .TIMEOUT(0), .CNT_W(4)) dut_nt (
    .clock(clock), .reset(reset), .enable(enable), .valid(valid), .ready(ready), .data(data),
    .err_valid_drop(vd1), .err_data_change(dc1), .err_timeout(to1), .err_any(any1),
    .first_err_chan(fch1), .first_err_code(fcd1));

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Model: age = number of cycles the channel has spent in a stall (first stalled cycle = 1).
  bit            m_pend [2][CH];
  int            m_age  [2][CH];
  logic [DW-1:0] m_cap  [2][CH];
  logic [CH-1:0] e_vd [2], e_dc [2], e_to [2];
  int            e_chan [2], e_code [2];

  function automatic int timeout_of(int m);
    return (m == 0) ? 8 : 0;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < CH; i++) begin
        m_pend[m][i] = 1'b0;
        m_age[m][i]  = 0;
        m_cap[m][i]  = '0;
      end
      e_vd[m] = '0; e_dc[m] = '0; e_to[m] = '0;
      e_chan[m] = 0; e_code[m] = 0;
    end
  endtask

  task automatic model_step();
    int fc, fch;
    bit vd, dc, to;
    logic [DW-1:0] d;
    for (int m = 0; m < 2; m++) begin
      fc = 0; fch = 0;
      for (int i = 0; i < CH; i++) begin
        vd = 0; dc = 0; to = 0;
        d = data[i*DW +: DW];
        if (!enable) begin
          m_pend[m][i] = 1'b0;
        end else if (!m_pend[m][i]) begin
          if (valid[i] && !ready[i]) begin
            m_pend[m][i] = 1'b1;
            m_age[m][i]  = 1;
            m_cap[m][i]  = d;
          end
        end else if (!valid[i]) begin
          vd = 1;
          m_pend[m][i] = 1'b0;
        end else begin
          dc = (d != m_cap[m][i]);
          if (ready[i]) m_pend[m][i] = 1'b0;
          else begin
            to = (timeout_of(m) != 0) && (m_age[m][i] == timeout_of(m));
            m_age[m][i]++;
          end
        end
        e_vd[m][i] = e_vd[m][i] | vd;
        e_dc[m][i] = e_dc[m][i] | dc;
        e_to[m][i] = e_to[m][i] | to;
        if (fc == 0 && (vd || dc || to)) begin
          fch = i;
          fc  = vd ? 1 : (dc ? 2 : 3);
        end
      end
      if (e_code[m] == 0 && fc != 0) begin
        e_code[m] = fc;
        e_chan[m] = fch;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("vd0", 32'(vd0), 32'(e_vd[0]));
    chk("dc0", 32'(dc0), 32'(e_dc[0]));
    chk("to0", 32'(to0), 32'(e_to[0]));
    chk("any0", 32'(any0), 32'(|{e_vd[0], e_dc[0], e_to[0]}));
    chk("fch0", 32'(fch0), 32'(e_chan[0]));
    chk("fcd0", 32'(fcd0), 32'(e_code[0]));
    chk("vd1", 32'(vd1), 32'(e_vd[1]));
    chk("dc1", 32'(dc1), 32'(e_dc[1]));
    chk("to1", 32'(to1), 32'(e_to[1]));
    chk("any1", 32'(any1), 32'(|{e_vd[1], e_dc[1], e_to[1]}));
    chk("fch1", 32'(fch1), 32'(e_chan[1]));
    chk("fcd1", 32'(fcd1), 32'(e_code[1]));
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_clear();
    else model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic drive(int ch, bit v, bit r, logic [DW-1:0] d);
    valid[ch] = v;
    ready[ch] = r;
    data[ch*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; valid = '0; ready = '0; data = '0;
    model_clear();
    tick(); tick();
    chk("rst_any", 32'(any0), 32'd0);
    chk("rst_code", 32'(fcd0), 32'd0);
    reset = 1'b0;

    // Clean stall then handshake
    drive(0, 1, 0, 32'hA5A5A5A5);
    repeat (3) tick();
    drive(0, 1, 1, 32'hA5A5A5A5); tick();
    drive(0, 0, 0, 32'h0); tick();
    chk("clean_any", 32'(any0), 32'd0);

    // Data change on ch1
    drive(1, 1, 0, 32'h1); tick();
    drive(1, 1, 0, 32'h2); tick();
    chk("dc_bits", 32'(dc0), 32'b10);
    chk("dc_chan", 32'(fch0), 32'd1);
    chk("dc_code", 32'(fcd0), 32'd2);
    drive(1, 0, 0, 32'h0); tick();
    do_reset();

    // Valid drop on ch0, later ch1 timeout must not overwrite first error
    drive(0, 1, 0, 32'h7); repeat (3) tick();
    drive(0, 0, 0, 32'h7); tick();
    chk("vd_bits", 32'(vd0), 32'b01);
    chk("vd_code", 32'(fcd0), 32'd1);
    drive(1, 1, 0, 32'h9); repeat (12) tick();
    chk("late_to", 32'(to0), 32'b10);
    chk("late_chan", 32'(fch0), 32'd0);
    chk("late_code", 32'(fcd0), 32'd1);
    drive(1, 0, 0, 32'h0); tick();
    do_reset();

    // Timeout edge: entry cycle + 8 stalled cycles
    drive(0, 1, 0, 32'h3); repeat (8) tick();
    chk("to_before", 32'(to0), 32'd0);
    tick();
    chk("to_rise", 32'(to0), 32'b01);
    chk("to_code", 32'(fcd0), 32'd3);
    repeat (11) tick();
    chk("to_hold", 32'(to0), 32'b01);
    chk("to_zero_off", 32'(to1), 32'd0);
    drive(0, 0, 0, 32'h0); tick();
    do_reset();

    // Simultaneous valid drop
    drive(0, 1, 0, 32'h5); drive(1, 1, 0, 32'h6); repeat (2) tick();
    drive(0, 0, 0, 32'h5); drive(1, 0, 0, 32'h6); tick();
    chk("both_vd", 32'(vd0), 32'b11);
    chk("both_chan", 32'(fch0), 32'd0);
    chk("both_code", 32'(fcd0), 32'd1);

    // Asynchronous reset mid-stall with errors set
    drive(0, 1, 0, 32'h4); tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_vd", 32'(vd0), 32'd0);
    chk("arst_to", 32'(to0), 32'd0);
    chk("arst_any", 32'(any0), 32'd0);
    chk("arst_chan", 32'(fch0), 32'd0);
    chk("arst_code", 32'(fcd0), 32'd0);
    model_clear();
    tick();
    reset = 1'b0;

    // Enable low during a stall with a data change
    tick(); tick();
    enable = 1'b0; drive(0, 1, 0, 32'hBEEF); tick();
    enable = 1'b1; tick(); tick();
    chk("en_any", 32'(any0), 32'd0);
    drive(0, 1, 1, 32'hBEEF); tick();
    drive(0, 0, 0, 32'h0); tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      enable = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 9) == 0) valid[i] = ~valid[i];
        ready[i] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 14) == 0) data[i*DW +: DW] = 32'($urandom_range(0, 3));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
